// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

   localparam int unsigned SUB_SIZE_DEFAULT = 8;

   typedef enum logic [1:0] {
      SUB_IDLE  = 2'd0,
      SUB_SHIFT = 2'd1,
      SUB_DONE  = 2'd2
   } sub_state_e;

   // Counter width able to hold 0..size.
   function automatic int unsigned sub_cnt_width(input int unsigned size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// With SERIAL_SUB_OVF_EN defined the bus also carries the signed-overflow flag ovf.
interface serial_subtractor_if #(
   parameter int unsigned SIZE = serial_subtractor_pkg::SUB_SIZE_DEFAULT
);
   logic            start;
   logic [SIZE-1:0] in1;
   logic [SIZE-1:0] in2;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] out;
   logic            bout;
`ifdef SERIAL_SUB_OVF_EN
   logic            ovf;

   modport master (output start, in1, in2, input busy, done, out, bout, ovf);
   modport slave  (input start, in1, in2, output busy, done, out, bout, ovf);
`else
   modport master (output start, in1, in2, input busy, done, out, bout);
   modport slave  (input start, in1, in2, output busy, done, out, bout);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial SIZE-bit subtractor (out = in1 - in2, bout = borrow), LSB first, one bit per clock.
// Optional SERIAL_SUB_OVF_EN adds the signed overflow flag ovf on the bus.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned SIZE = SUB_SIZE_DEFAULT
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CNT_W = sub_cnt_width(SIZE);

   sub_state_e       state;
   logic [SIZE-1:0]  a;
   logic [SIZE-1:0]  b;
   logic [SIZE-1:0]  r;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic [SIZE-1:0]  out_q;
   logic             bout_q;

   logic             d_c;
   logic             bout_c;
   logic [SIZE-1:0]  r_next_c;

   full_subtractor_bit u_bit (
      .a    (a[0]),
      .b    (b[0]),
      .bin  (br),
      .d    (d_c),
      .bout (bout_c)
   );

   // Result shifts in from the MSB end so the LSB-first stream lands in place.
   generate
      if (SIZE == 1) begin : g_r1
         assign r_next_c = d_c;
      end else begin : g_rn
         assign r_next_c = {d_c, r[SIZE-1:1]};
      end
   endgenerate

`ifdef SERIAL_SUB_OVF_EN
   logic sign_a;
   logic sign_b;
   logic ovf_q;
   assign bus.ovf = ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= SUB_IDLE;
         a      <= '0;
         b      <= '0;
         r      <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         out_q  <= '0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else begin
         case (state)
            SUB_IDLE: begin
               if (bus.start) begin
                  a      <= bus.in1;
                  b      <= bus.in2;
                  r      <= '0;
                  br     <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SUB_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  sign_a <= bus.in1[SIZE-1];
                  sign_b <= bus.in2[SIZE-1];
`endif
               end
            end
            SUB_SHIFT: begin
               r   <= r_next_c;
               br  <= bout_c;
               a   <= a >> 1;
               b   <= b >> 1;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(SIZE - 1)) begin
                  state  <= SUB_DONE;
                  done_q <= 1'b1;
                  out_q  <= r_next_c;
                  bout_q <= bout_c;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q  <= (sign_a != sign_b) && (r_next_c[SIZE-1] != sign_a);
`endif
               end
            end
            SUB_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= SUB_IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= SUB_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (SIZE=8 plus a SIZE=1 instance).
// Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

   localparam int unsigned SIZE = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_subtractor_if #(.SIZE(SIZE)) bus  ();
   serial_subtractor_if #(.SIZE(1))    bus1 ();

   serial_subtractor #(.SIZE(SIZE)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   serial_subtractor #(.SIZE(1))    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1..SIZE computing, SIZE+1 result cycle.
   int         m_phase = 0;
   logic [7:0] m_res   = '0;
   logic       m_bres  = 1'b0;
   logic       m_ovres = 1'b0;
   logic [7:0] m_out   = '0;
   logic       m_bout  = 1'b0;
   logic       m_ovf   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_out   = '0;
         m_bout  = 1'b0;
         m_ovf   = 1'b0;
      end else if (m_phase == 0) begin
         if (bus.start) begin
            m_res   = bus.in1 - bus.in2;
            m_bres  = (bus.in1 < bus.in2);
            m_ovres = (bus.in1[7] != bus.in2[7]) && (m_res[7] != bus.in1[7]);
            m_phase = 1;
         end
      end else if (m_phase < int'(SIZE)) begin
         m_phase = m_phase + 1;
      end else if (m_phase == int'(SIZE)) begin
         m_phase = int'(SIZE) + 1;
         m_out   = m_res;
         m_bout  = m_bres;
         m_ovf   = m_ovres;
      end else begin
         m_phase = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n && cmp_en) begin
         chk("model_busy", 32'(bus.busy), 32'(m_phase != 0));
         chk("model_done", 32'(bus.done), 32'(m_phase == int'(SIZE) + 1));
         chk("model_out",  32'(bus.out),  32'(m_out));
         chk("model_bout", 32'(bus.bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
         chk("model_ovf",  32'(bus.ovf),  32'(m_ovf));
`endif
      end
   end

   // One operation on the SIZE=8 instance; returns edges from start edge to done.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y, output int lat);
      lat = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = x;
      bus.in2   = y;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.in1   = 8'($urandom);
      bus.in2   = 8'($urandom);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #2;
         chk("busy_during_op", 32'(bus.busy), 32'd1);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      chk("done_single_pulse", 32'(bus.done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int dc[$];
      bus.start  = 1'b0;
      bus.in1    = '0;
      bus.in2    = '0;
      bus1.start = 1'b0;
      bus1.in1   = '0;
      bus1.in2   = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_out",  32'(bus.out),  32'd0);
      chk("reset_bout", 32'(bus.bout), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      run_op(8'd255, 8'd1, lat);
      chk("t1_latency", 32'(lat), 32'd8);
      chk("t1_out",  32'(bus.out),  32'd254);
      chk("t1_bout", 32'(bus.bout), 32'd0);

      run_op(8'd1, 8'd255, lat);
      chk("t2a_out",  32'(bus.out),  32'd2);
      chk("t2a_bout", 32'(bus.bout), 32'd1);
      run_op(8'd0, 8'd0, lat);
      chk("t2b_out",  32'(bus.out),  32'd0);
      chk("t2b_bout", 32'(bus.bout), 32'd0);

      run_op(8'd128, 8'd1, lat);
      chk("t3a_out", 32'(bus.out), 32'd127);
`ifdef SERIAL_SUB_OVF_EN
      chk("t3a_ovf", 32'(bus.ovf), 32'd1);
`endif
      run_op(8'd5, 8'd3, lat);
      chk("t3b_out", 32'(bus.out), 32'd2);
`ifdef SERIAL_SUB_OVF_EN
      chk("t3b_ovf", 32'(bus.ovf), 32'd0);
`endif

      // start held high with fresh operands every cycle
      @(negedge clk);
      bus.start = 1'b1;
      for (int c = 0; c < 50; c++) begin
         bus.in1 = 8'($urandom);
         bus.in2 = 8'($urandom);
         @(posedge clk);
         #2;
         if (bus.done) dc.push_back(c);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("t4_done_count", 32'(dc.size() >= 4), 32'd1);
      for (int i = 1; i < dc.size(); i++)
         chk("t4_done_spacing", 32'(dc[i] - dc[i-1]), 32'(SIZE + 2));
      repeat (12) @(posedge clk);

      // abort in the 4th SHIFT cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 8'd200;
      bus.in2   = 8'd17;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_abort_busy", 32'(bus.busy), 32'd0);
      chk("t5_abort_done", 32'(bus.done), 32'd0);
      chk("t5_abort_out",  32'(bus.out),  32'd0);
      chk("t5_abort_bout", 32'(bus.bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'd100, 8'd37, lat);
      chk("t5_latency", 32'(lat), 32'd8);
      chk("t5_out",  32'(bus.out),  32'd63);
      chk("t5_bout", 32'(bus.bout), 32'd0);

      // random traffic, checked every cycle against the model
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.in1   = 8'($urandom);
         bus.in2   = 8'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(posedge clk);

      // SIZE=1 instance, all operand pairs
      for (int x = 0; x < 2; x++) begin
         for (int y = 0; y < 2; y++) begin
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.in1   = 1'(x);
            bus1.in2   = 1'(y);
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            @(posedge clk);
            #2;
            chk("s1_done",  32'(bus1.done), 32'd1);
            chk("s1_out",   32'(bus1.out),  32'((x - y) & 1));
            chk("s1_bout",  32'(bus1.bout), 32'(x < y));
            @(posedge clk);
            #2;
            chk("s1_done_end", 32'(bus1.done), 32'd0);
         end
      end
      // literal pin for 0-1 (last result for x=1,y=1 is 0; rerun 0-1)
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.in1   = 1'b0;
      bus1.in2   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      @(posedge clk);
      #2;
      chk("s1_lit_done", 32'(bus1.done), 32'd1);
      chk("s1_lit_out",  32'(bus1.out),  32'd1);
      chk("s1_lit_bout", 32'(bus1.bout), 32'd1);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
